// File: rtl/s4_wb_buffer_pkg.sv
// Shared widths and depth for the s4 write-back buffer slice; defaults for the top-level parameters.
package s4_wb_buffer_pkg;
  localparam int unsigned WB_ENTRIES = 4;
  localparam int unsigned WB_IDX_W   = 6;
  localparam int unsigned WB_WAY_W   = 2;
  localparam int unsigned WB_OFF_W   = 3;
  localparam int unsigned WB_DATA_W  = 64;
endpackage

// File: rtl/s4_wb_buffer_wb_age_select.sv
// Youngest-match select over a circular queue: combinational hit flag and one-hot slot of the newest matching entry.
// No state, no backpressure; walks oldest to youngest so the last match wins.
module wb_age_select
  import s4_wb_buffer_pkg::*;
#(
  parameter int unsigned ENTRIES = WB_ENTRIES,
  localparam int unsigned PTR_W  = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0] match,
  input  logic [PTR_W-1:0]   head,
  input  logic [PTR_W:0]     count,
  output logic               hit,
  output logic [ENTRIES-1:0] sel
);

  logic [PTR_W-1:0] pos;

  always_comb begin
    hit = 1'b0;
    sel = '0;
    pos = '0;
    for (int k = 0; k < ENTRIES; k++) begin
      pos = head + PTR_W'(k);
      if (((PTR_W+1)'(k) < count) && match[pos]) begin
        hit      = 1'b1;
        sel      = '0;
        sel[pos] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/s4_wb_buffer.sv
// s3 AMO write-back FIFO with youngest-entry coalescing; enqueue -> io_wr_valid in 1 cycle, 1 enq + 1 deq per cycle.
// Backpressure: io_req_ready drops only when full (registered state); optional s2 bypass under NBDCACHE_WB_BYPASS_EN.
module s4_wb_buffer
  import s4_wb_buffer_pkg::*;
#(
  parameter int unsigned ENTRIES = WB_ENTRIES,
  parameter int unsigned IDX_W   = WB_IDX_W,
  parameter int unsigned WAY_W   = WB_WAY_W,
  parameter int unsigned OFF_W   = WB_OFF_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_req_valid,
  output logic                 io_req_ready,
  input  logic [IDX_W-1:0]     io_req_idx,
  input  logic [WAY_W-1:0]     io_req_way,
  input  logic [OFF_W-1:0]     io_req_off,
  input  logic [WB_DATA_W-1:0] io_req_data,
  output logic                 io_wr_valid,
  input  logic                 io_wr_ready,
  output logic [IDX_W-1:0]     io_wr_idx,
  output logic [WAY_W-1:0]     io_wr_way,
  output logic [OFF_W-1:0]     io_wr_off,
  output logic [WB_DATA_W-1:0] io_wr_data,
  input  logic [IDX_W-1:0]     io_byp_idx,
  input  logic [WAY_W-1:0]     io_byp_way,
  input  logic [OFF_W-1:0]     io_byp_off,
  output logic                 io_byp_hit,
  output logic [WB_DATA_W-1:0] io_byp_data,
  output logic                 io_empty
);

  localparam int unsigned PTR_W = $clog2(ENTRIES);

  logic [PTR_W-1:0]     head, tail, tail_m1;
  logic [PTR_W:0]       count;
  logic [ENTRIES-1:0]   ent_vld;
  logic [IDX_W-1:0]     ent_idx  [ENTRIES];
  logic [WAY_W-1:0]     ent_way  [ENTRIES];
  logic [OFF_W-1:0]     ent_off  [ENTRIES];
  logic [WB_DATA_W-1:0] ent_data [ENTRIES];
  logic                 enq_fire, deq_fire, coalesce, alloc;

  assign io_req_ready = (count != (PTR_W+1)'(ENTRIES));
  assign io_wr_valid  = (count != '0);
  assign io_empty     = (count == '0);
  assign enq_fire     = io_req_valid && io_req_ready;
  assign deq_fire     = io_wr_valid && io_wr_ready;
  assign tail_m1      = tail - PTR_W'(1);

  // count >= 2 keeps the head (payload on the write port) out of coalescing
  assign coalesce = enq_fire && (count >= (PTR_W+1)'(2)) &&
                    (ent_idx[tail_m1] == io_req_idx) &&
                    (ent_way[tail_m1] == io_req_way) &&
                    (ent_off[tail_m1] == io_req_off);
  assign alloc    = enq_fire && !coalesce;

  assign io_wr_idx  = ent_idx[head];
  assign io_wr_way  = ent_way[head];
  assign io_wr_off  = ent_off[head];
  assign io_wr_data = ent_data[head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ent_vld <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ent_idx[i]  <= '0;
        ent_way[i]  <= '0;
        ent_off[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (deq_fire) begin
        head          <= head + PTR_W'(1);
        ent_vld[head] <= 1'b0;
      end
      if (alloc) begin
        tail           <= tail + PTR_W'(1);
        ent_vld[tail]  <= 1'b1;
        ent_idx[tail]  <= io_req_idx;
        ent_way[tail]  <= io_req_way;
        ent_off[tail]  <= io_req_off;
        ent_data[tail] <= io_req_data;
      end
      if (coalesce) begin
        ent_data[tail_m1] <= io_req_data;
      end
      case ({alloc, deq_fire})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef NBDCACHE_WB_BYPASS_EN
  logic [ENTRIES-1:0] byp_match, byp_sel;

  always_comb begin
    byp_match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      byp_match[i] = ent_vld[i] && (ent_idx[i] == io_byp_idx) &&
                     (ent_way[i] == io_byp_way) && (ent_off[i] == io_byp_off);
    end
  end

  wb_age_select #(.ENTRIES(ENTRIES)) u_age_select (
    .match (byp_match),
    .head  (head),
    .count (count),
    .hit   (io_byp_hit),
    .sel   (byp_sel)
  );

  always_comb begin
    io_byp_data = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (byp_sel[i]) io_byp_data = io_byp_data | ent_data[i];
    end
  end
`else
  // s2 must stall on a location conflict while the buffer is non-empty
  logic unused_byp;
  assign unused_byp  = ^{io_byp_idx, io_byp_way, io_byp_off, ent_vld};
  assign io_byp_hit  = 1'b0;
  assign io_byp_data = '0;
`endif

endmodule

// File: tb/tb_s4_wb_buffer.sv
// Directed bench for s4_wb_buffer: reset, latency/hold, full/wrap, coalescing, bypass and async reset.
module tb_s4_wb_buffer;

`ifdef NBDCACHE_WB_BYPASS_EN
  localparam bit BYP_ON = 1'b1;
`else
  localparam bit BYP_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_req_valid = 1'b0;
  logic        io_req_ready;
  logic [5:0]  io_req_idx = '0;
  logic [1:0]  io_req_way = '0;
  logic [2:0]  io_req_off = '0;
  logic [63:0] io_req_data = '0;
  logic        io_wr_valid;
  logic        io_wr_ready = 1'b0;
  logic [5:0]  io_wr_idx;
  logic [1:0]  io_wr_way;
  logic [2:0]  io_wr_off;
  logic [63:0] io_wr_data;
  logic [5:0]  io_byp_idx = '0;
  logic [1:0]  io_byp_way = '0;
  logic [2:0]  io_byp_off = '0;
  logic        io_byp_hit;
  logic [63:0] io_byp_data;
  logic        io_empty;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  s4_wb_buffer dut (
    .clk          (clk),
    .reset        (reset),
    .io_req_valid (io_req_valid),
    .io_req_ready (io_req_ready),
    .io_req_idx   (io_req_idx),
    .io_req_way   (io_req_way),
    .io_req_off   (io_req_off),
    .io_req_data  (io_req_data),
    .io_wr_valid  (io_wr_valid),
    .io_wr_ready  (io_wr_ready),
    .io_wr_idx    (io_wr_idx),
    .io_wr_way    (io_wr_way),
    .io_wr_off    (io_wr_off),
    .io_wr_data   (io_wr_data),
    .io_byp_idx   (io_byp_idx),
    .io_byp_way   (io_byp_way),
    .io_byp_off   (io_byp_off),
    .io_byp_hit   (io_byp_hit),
    .io_byp_data  (io_byp_data),
    .io_empty     (io_empty)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [5:0] idx, input logic [1:0] way, input logic [2:0] off,
                     input logic [63:0] data);
    io_req_valid = 1'b1;
    io_req_idx   = idx;
    io_req_way   = way;
    io_req_off   = off;
    io_req_data  = data;
    step();
    io_req_valid = 1'b0;
  endtask

  initial begin
    // reset state, observed while reset is held
    #3;
    chk("rst_wr_valid", 64'(io_wr_valid), 64'd0);
    chk("rst_req_ready", 64'(io_req_ready), 64'd1);
    chk("rst_empty", 64'(io_empty), 64'd1);
    chk("rst_byp_hit", 64'(io_byp_hit), 64'd0);
    chk("rst_byp_data", io_byp_data, 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("idle_wr_valid", 64'(io_wr_valid), 64'd0);
    chk("idle_empty", 64'(io_empty), 64'd1);

    // single enqueue: visible next cycle, payload held while stalled
    enq(6'd5, 2'd1, 3'd2, 64'h1122334455667788);
    for (int c = 0; c < 3; c++) begin
      chk("lat_wr_valid", 64'(io_wr_valid), 64'd1);
      chk("lat_wr_idx", 64'(io_wr_idx), 64'd5);
      chk("lat_wr_way", 64'(io_wr_way), 64'd1);
      chk("lat_wr_off", 64'(io_wr_off), 64'd2);
      chk("lat_wr_data", io_wr_data, 64'h1122334455667788);
      if (c < 2) step();
    end
    io_wr_ready = 1'b1;
    step();
    io_wr_ready = 1'b0;
    chk("lat_drained_empty", 64'(io_empty), 64'd1);
    chk("lat_drained_wr_valid", 64'(io_wr_valid), 64'd0);

    // fill to full (head/tail now at 1, so the queue wraps)
    for (int i = 0; i < 4; i++) enq(6'(10 + i), 2'd0, 3'd0, 64'h100 + 64'(i));
    chk("full_req_ready", 64'(io_req_ready), 64'd0);
    chk("full_head_idx", 64'(io_wr_idx), 64'd10);
    io_req_valid = 1'b1;
    io_req_idx   = 6'd14;
    io_req_way   = 2'd0;
    io_req_off   = 3'd0;
    io_req_data  = 64'h104;
    step();
    chk("full_hold_ready", 64'(io_req_ready), 64'd0);
    chk("full_hold_head", 64'(io_wr_idx), 64'd10);
    io_wr_ready = 1'b1;
    step();
    io_wr_ready = 1'b0;
    chk("full_ready_back", 64'(io_req_ready), 64'd1);
    chk("full_head_after_deq", 64'(io_wr_idx), 64'd11);
    step();
    io_req_valid = 1'b0;
    chk("full_again_ready", 64'(io_req_ready), 64'd0);
    io_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_wr_valid", 64'(io_wr_valid), 64'd1);
      chk("wrap_wr_idx", 64'(io_wr_idx), 64'(11 + i));
      chk("wrap_wr_data", io_wr_data, 64'h101 + 64'(i));
      step();
    end
    io_wr_ready = 1'b0;
    chk("wrap_empty", 64'(io_empty), 64'd1);

    // coalescing into the youngest entry
    enq(6'd1, 2'd0, 3'd0, 64'h10);
    enq(6'd2, 2'd0, 3'd0, 64'h20);
    enq(6'd2, 2'd0, 3'd0, 64'h21);
    io_wr_ready = 1'b1;
    chk("coal_a_idx", 64'(io_wr_idx), 64'd1);
    chk("coal_a_data", io_wr_data, 64'h10);
    step();
    chk("coal_b_idx", 64'(io_wr_idx), 64'd2);
    chk("coal_b_data", io_wr_data, 64'h21);
    step();
    chk("coal_empty", 64'(io_empty), 64'd1);
    io_wr_ready = 1'b0;

    // head-only match (count 1) must allocate, not overwrite the head
    enq(6'd6, 2'd0, 3'd0, 64'h60);
    enq(6'd6, 2'd0, 3'd0, 64'h61);
    io_wr_ready = 1'b1;
    chk("nocoal_head_data", io_wr_data, 64'h60);
    step();
    chk("nocoal_second_valid", 64'(io_wr_valid), 64'd1);
    chk("nocoal_second_data", io_wr_data, 64'h61);
    step();
    chk("nocoal_empty", 64'(io_empty), 64'd1);
    io_wr_ready = 1'b0;

    // bypass: youngest match wins, miss returns zero
    enq(6'd3, 2'd0, 3'd0, 64'hAA);
    enq(6'd4, 2'd0, 3'd0, 64'hBB);
    enq(6'd3, 2'd0, 3'd0, 64'hCC);
    io_byp_idx = 6'd3;
    #1;
    chk("byp3_hit", 64'(io_byp_hit), BYP_ON ? 64'd1 : 64'd0);
    chk("byp3_data", io_byp_data, BYP_ON ? 64'hCC : 64'd0);
    io_byp_idx = 6'd4;
    #1;
    chk("byp4_data", io_byp_data, BYP_ON ? 64'hBB : 64'd0);
    io_byp_idx = 6'd7;
    #1;
    chk("byp7_hit", 64'(io_byp_hit), 64'd0);
    chk("byp7_data", io_byp_data, 64'd0);
    io_req_valid = 1'b1;
    io_req_idx   = 6'd7;
    io_req_data  = 64'h77;
    #1;
    chk("byp_same_cycle_hit", 64'(io_byp_hit), 64'd0);
    step();
    io_req_valid = 1'b0;
    chk("byp_next_cycle_hit", 64'(io_byp_hit), BYP_ON ? 64'd1 : 64'd0);
    chk("byp_next_cycle_data", io_byp_data, BYP_ON ? 64'h77 : 64'd0);
    chk("byp_full_ready", 64'(io_req_ready), 64'd0);

    // async reset with entries queued takes effect without a clock edge
    reset = 1'b1;
    #2;
    chk("arst_wr_valid", 64'(io_wr_valid), 64'd0);
    chk("arst_empty", 64'(io_empty), 64'd1);
    chk("arst_req_ready", 64'(io_req_ready), 64'd1);
    chk("arst_byp_hit", 64'(io_byp_hit), 64'd0);
    step();
    reset = 1'b0;
    enq(6'd9, 2'd3, 3'd7, 64'hDEAD_BEEF);
    chk("post_rst_idx", 64'(io_wr_idx), 64'd9);
    chk("post_rst_data", io_wr_data, 64'hDEAD_BEEF);
    chk("post_rst_byp_old", 64'(io_byp_hit), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
